// File: rtl/gs_rom_arb.sv
// gs_rom_arb: shares one single-port GS ROM between FIFO-buffered loader writes and GS CPU reads.
// Define GS_ROM_ARB_CSUM_EN to add the csum output (running sum of committed write bytes).
module gs_rom_arb #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned AW         = 15
) (
  input  logic                        clk_bus,
  input  logic                        reset,
  input  logic                        loader_act,
  input  logic [31:0]                 loader_a,
  input  logic [7:0]                  loader_d,
  input  logic                        loader_wr,
  input  logic                        gs_rd_req,
  input  logic [AW-1:0]               gs_a,
  output logic [7:0]                  gs_dout,
  output logic                        gs_rd_ack,
  output logic [AW-1:0]               mem_a,
  output logic [7:0]                  mem_d,
  output logic                        mem_we,
  input  logic [7:0]                  mem_q,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        ovf,
`ifdef GS_ROM_ARB_CSUM_EN
  output logic [7:0]                  csum,
`endif
  output logic                        wr_idle
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = AW + 8;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_RESP,
    S_WRITE
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            act_q, act_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [7:0]      mem_d_q, mem_d_d;
  logic            mem_we_q, mem_we_d;
  logic [7:0]      gs_dout_q, gs_dout_d;
  logic            gs_rd_ack_q, gs_rd_ack_d;

  logic            push, push_ok, pop, rd_grant, fifo_ne, act_rise;
  logic [EW-1:0]   push_ent, pop_ent;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^loader_a[30:AW];

  always_comb begin
    push     = loader_act & loader_wr & loader_a[31];
    push_ent = {loader_a[AW-1:0], loader_d};
    pop_ent  = fifo_mem_q[rd_ptr_q];
    fifo_ne  = (level_q != '0);
    act_rise = loader_act & ~act_q;
    state_d  = state_q;
    pop      = 1'b0;
    rd_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The ack cycle grants nothing: the requester is still dropping its req.
        if (!gs_rd_ack_q) begin
          if (fifo_ne && (starve_q == STARVE_L)) begin
            state_d = S_WRITE;
            pop     = 1'b1;
          end else if (gs_rd_req) begin
            state_d  = S_READ;
            rd_grant = 1'b1;
          end else if (fifo_ne) begin
            state_d = S_WRITE;
            pop     = 1'b1;
          end
        end
      end
      S_READ:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    push_ok  = push & ((level_q < DEPTH_L) | pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    starve_d = starve_q;
    if (!fifo_ne || pop) begin
      starve_d = '0;
    end else if (rd_grant && (starve_q != STARVE_L)) begin
      starve_d = starve_q + SW'(1);
    end

    act_d = loader_act;
    ovf_d = act_rise ? 1'b0 : ovf_q;
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end

    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    mem_we_d = pop;
    if (rd_grant) begin
      mem_a_d = gs_a;
    end
    if (pop) begin
      mem_a_d = pop_ent[EW-1:8];
      mem_d_d = pop_ent[7:0];
    end

    gs_rd_ack_d = (state_q == S_RESP);
    gs_dout_d   = (state_q == S_RESP) ? mem_q : gs_dout_q;
  end

  always_ff @(posedge clk_bus) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= push_ent;
    end
  end

  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      starve_q    <= '0;
      act_q       <= 1'b0;
      ovf_q       <= 1'b0;
      mem_a_q     <= '0;
      mem_d_q     <= '0;
      mem_we_q    <= 1'b0;
      gs_dout_q   <= '0;
      gs_rd_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      starve_q    <= starve_d;
      act_q       <= act_d;
      ovf_q       <= ovf_d;
      mem_a_q     <= mem_a_d;
      mem_d_q     <= mem_d_d;
      mem_we_q    <= mem_we_d;
      gs_dout_q   <= gs_dout_d;
      gs_rd_ack_q <= gs_rd_ack_d;
    end
  end

`ifdef GS_ROM_ARB_CSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q + (mem_we_q ? mem_d_q : 8'h00);
    if (act_rise) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clk_bus or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

  assign gs_dout    = gs_dout_q;
  assign gs_rd_ack  = gs_rd_ack_q;
  assign mem_a      = mem_a_q;
  assign mem_d      = mem_d_q;
  assign mem_we     = mem_we_q;
  assign fifo_level = level_q;
  assign ovf        = ovf_q;
  assign wr_idle    = (level_q == '0) && (state_q != S_WRITE);

endmodule

// File: tb/tb_gs_rom_arb.sv
// Bench for gs_rom_arb: directed scenarios plus random traffic against a transaction-level model.
// Build with GS_ROM_ARB_CSUM_EN defined to also cover the checksum output.
module tb_gs_rom_arb;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int AW    = 15;
  localparam int EW    = AW + 8;

  logic          clk_bus = 1'b0;
  logic          reset = 1'b0;
  logic          loader_act = 1'b0, loader_wr = 1'b0, gs_rd_req = 1'b0;
  logic [31:0]   loader_a = '0;
  logic [7:0]    loader_d = '0;
  logic [AW-1:0] gs_a = '0;
  logic [7:0]    gs_dout, mem_d, mem_q;
  logic          gs_rd_ack, mem_we, ovf, wr_idle;
  logic [AW-1:0] mem_a;
  logic [2:0]    fifo_level;
`ifdef GS_ROM_ARB_CSUM_EN
  logic [7:0]    csum;
`endif

  gs_rom_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX), .AW(AW)) u_dut (
    .clk_bus(clk_bus), .reset(reset), .loader_act(loader_act), .loader_a(loader_a),
    .loader_d(loader_d), .loader_wr(loader_wr), .gs_rd_req(gs_rd_req), .gs_a(gs_a),
    .gs_dout(gs_dout), .gs_rd_ack(gs_rd_ack), .mem_a(mem_a), .mem_d(mem_d),
    .mem_we(mem_we), .mem_q(mem_q), .fifo_level(fifo_level), .ovf(ovf),
`ifdef GS_ROM_ARB_CSUM_EN
    .csum(csum),
`endif
    .wr_idle(wr_idle)
  );

  always #5 clk_bus = ~clk_bus;

  // ROM storage: registered read, write on mem_we
  logic [7:0] mem     [0:(1<<AW)-1];
  logic [7:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk_bus) begin
    mem_q <= mem[mem_a];
    if (mem_we === 1'b1) mem[mem_a] = mem_d;
  end

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: FIFO as a queue, arbiter as "busy until" cycle plus scheduled events
  logic [EW-1:0] q[$];
  int            starve, free_at, ack_cyc, we_cyc, ra_cyc;
  logic [7:0]    m_ack_data, m_dout, m_memd, m_we_d, m_csum;
  logic [AW-1:0] m_mema, m_ra, m_we_a;
  bit            m_ovf, m_act_prev;

  task automatic model_reset();
    q.delete();
    starve = 0; free_at = 0; ack_cyc = -1; we_cyc = -1; ra_cyc = -1;
    m_ack_data = '0; m_dout = '0; m_memd = '0; m_we_d = '0; m_csum = '0;
    m_mema = '0; m_ra = '0; m_we_a = '0; m_ovf = 0; m_act_prev = 0;
  endtask

  task automatic model_step();
    bit rise, popped, drop, csum_add;
    int sz;
    logic [7:0] cadd;
    logic [EW-1:0] e;
    rise = loader_act && !m_act_prev;
    m_act_prev = loader_act;
    sz = q.size();
    popped = 0;
    drop = 0;
    csum_add = (we_cyc == cyc);
    cadd = m_we_d;
    if (cyc >= free_at && ack_cyc != cyc) begin
      if (sz != 0 && starve == SMAX) popped = 1;
      else if (gs_rd_req) begin
        ra_cyc = cyc + 1; m_ra = gs_a;
        ack_cyc = cyc + 3; m_ack_data = ref_mem[gs_a];
        free_at = cyc + 3;
        if (sz != 0 && starve < SMAX) starve++;
      end else if (sz != 0) popped = 1;
    end
    if (popped) begin
      e = q.pop_front();
      m_we_a = e[EW-1:8]; m_we_d = e[7:0];
      ref_mem[m_we_a] = m_we_d;
      we_cyc = cyc + 1; free_at = cyc + 2; starve = 0;
    end
    if (sz == 0) starve = 0;
    if (loader_act && loader_wr && loader_a[31]) begin
      if (sz < DEPTH || popped) q.push_back({loader_a[AW-1:0], loader_d});
      else drop = 1;
    end
    if (rise) m_ovf = 0;
    if (drop) m_ovf = 1;
    if (rise) m_csum = '0;
    else if (csum_add) m_csum = m_csum + cadd;
  endtask

  task automatic check_outputs();
    chk("ack", gs_rd_ack, ack_cyc == cyc);
    if (ack_cyc == cyc) m_dout = m_ack_data;
    chk("dout", gs_dout, m_dout);
    chk("mem_we", mem_we, we_cyc == cyc);
    if (we_cyc == cyc) begin m_mema = m_we_a; m_memd = m_we_d; end
    if (ra_cyc == cyc) m_mema = m_ra;
    chk("mem_a", mem_a, m_mema);
    chk("mem_d", mem_d, m_memd);
    chk("fifo_level", fifo_level, q.size());
    chk("ovf", ovf, m_ovf);
    chk("wr_idle", wr_idle, (q.size() == 0) && (we_cyc != cyc));
`ifdef GS_ROM_ARB_CSUM_EN
    chk("csum", csum, m_csum);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_bus);
    #1;
    cyc++;
    check_outputs();
  endtask

  // GS requester: holds req until ack, drops it on the ack cycle
  task automatic req_auto(input int pct);
    if (gs_rd_req && ack_cyc == cyc) gs_rd_req = 1'b0;
    else if (!gs_rd_req && $urandom_range(99) < pct) begin
      gs_rd_req = 1'b1;
      gs_a = AW'($urandom_range(15));
    end
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      req_auto(pct);
      tick();
    end
  endtask

  task automatic push_byte(input logic [31:0] a, input logic [7:0] d, input int pct);
    loader_wr = 1'b1; loader_a = a; loader_d = d;
    req_auto(pct);
    tick();
    loader_wr = 1'b0;
  endtask

  int ack_at, nack, nwr, t0;
  logic [7:0] dout_at;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[15'h7FFF] = 8'hC3;
    ref_mem[15'h7FFF] = 8'hC3;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_bus);
    #1;
    reset = 1'b0;
    check_outputs();

    // Idle write
    loader_act = 1'b1;
    run(2, 0);
    push_byte(32'h8000_0123, 8'h5A, 0);
    tick();
    chk("iw_we", mem_we, 1);
    chk("iw_a", mem_a, 15'h0123);
    chk("iw_d", mem_d, 8'h5A);
    tick();
    chk("iw_we_off", mem_we, 0);
    chk("iw_idle", wr_idle, 1);
    chk("iw_mem", mem[15'h0123], 8'h5A);

    // Read latency
    run(3, 0);
    gs_rd_req = 1'b1; gs_a = 15'h7FFF; t0 = cyc; nack = 0; ack_at = -1; dout_at = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) req_auto(0);
      tick();
      if (gs_rd_ack) begin nack++; ack_at = cyc; dout_at = gs_dout; end
    end
    chk("rd_latency", ack_at - t0, 3);
    chk("rd_ack_count", nack, 1);
    chk("rd_data", dout_at, 8'hC3);

    // Overflow with reads holding off every pop
    run(1, 100);
    for (int i = 0; i < 5; i++) push_byte(32'h8000_0300 + i, 8'(8'h40 + i), 100);
    chk("ovf_set", ovf, 1);
    chk("ovf_level", fifo_level, 4);
    loader_act = 1'b0;
    run(1, 100);
    loader_act = 1'b1;
    run(1, 100);
    chk("ovf_clear", ovf, 0);
    run(60, 0);

    // Starvation: continuous reads, two pending writes
    run(1, 100);
    push_byte(32'h8000_0400, 8'hA1, 100);
    push_byte(32'h8000_0401, 8'hA2, 100);
    nwr = 0;
    for (int i = 0; i < 80; i++) begin
      req_auto(100);
      tick();
      if (mem_we) nwr++;
    end
    chk("starve_writes", nwr, 2);
    chk("starve_drained", fifo_level, 0);
    run(10, 0);

    // Region filter
    push_byte(32'h0000_0042, 8'h77, 0);
    chk("region_level", fifo_level, 0);
    run(4, 0);
    chk("region_ovf", ovf, 0);

    // Reset during READ
    gs_rd_req = 1'b1; gs_a = 15'h0005;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_ack", gs_rd_ack, 0);
    chk("rst_dout", gs_dout, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_d", mem_d, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_wr_idle", wr_idle, 1);
    model_reset();
    gs_rd_req = 1'b0; loader_act = 1'b0;
    @(posedge clk_bus);
    #1;
    @(posedge clk_bus);
    #1;
    reset = 1'b0;
    check_outputs();
    run(6, 0);

`ifdef GS_ROM_ARB_CSUM_EN
    loader_act = 1'b1;
    run(2, 0);
    push_byte(32'h8000_0200, 8'hFF, 0);
    push_byte(32'h8000_0201, 8'h02, 0);
    push_byte(32'h8000_0202, 8'h10, 0);
    run(10, 0);
    chk("csum_sum", csum, 8'h11);
    loader_act = 1'b0;
    run(1, 0);
    loader_act = 1'b1;
    run(1, 0);
    chk("csum_clr", csum, 8'h00);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      loader_act = ($urandom_range(99) < 96);
      loader_wr  = ($urandom_range(99) < 35);
      loader_a   = {($urandom_range(9) != 0), 16'h0000, 15'($urandom_range(15))};
      loader_d   = 8'($urandom);
      req_auto(30);
      tick();
    end
    loader_wr = 1'b0;
    run(60, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gs_rom_arb.md
Name: gs_rom_arb

Overview:
- Single-clock arbiter/sequencer that shares one single-port 32 KB GS ROM array between two requesters:
  - loader byte writes, buffered in a small FIFO;
  - GS CPU reads, via a req/ack handshake.
- Sits between the loader bus and the GS ROM storage in the clk_bus domain and drives the memory's address, data and write-enable.
- A starvation guard prevents continuous reads from blocking the loader indefinitely.

Parameters:
FIFO_DEPTH, 4, loader write FIFO entries; power of 2, >=2
STARVE_MAX, 8, consecutive read grants allowed while FIFO non-empty before a write is forced
AW, 15, memory address width (32 KB)

Ports:
clk_bus  in  1  system clock
reset  in  1  asynchronous, active-high reset
loader_act  in  1  loader session active
loader_a  in  32  loader address; bit 31 selects GS ROM region
loader_d  in  8  loader data byte
loader_wr  in  1  loader write strobe, one cycle per byte
gs_rd_req  in  1  GS read request, level, held until gs_rd_ack
gs_a  in  AW  GS read address, stable while gs_rd_req high
gs_dout  out  8  read data, valid when gs_rd_ack high
gs_rd_ack  out  1  one-cycle read completion pulse
mem_a  out  AW  registered memory address
mem_d  out  8  registered memory write data
mem_we  out  1  registered memory write enable
mem_q  in  8  memory read data, valid one cycle after mem_a is presented
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
ovf  out  1  sticky: a loader byte was dropped
wr_idle  out  1  FIFO empty and state != WRITE

Behaviour:
- Reset (async, active-high): FSM=IDLE, FIFO emptied, starve_cnt=0.
  - Outputs: gs_dout=0, gs_rd_ack=0, mem_a=0, mem_d=0, mem_we=0, ovf=0, fifo_level=0, wr_idle=1.
  - Reset mid-read: no ack is issued. Reset mid-write: mem_we drops immediately.
- Push condition: loader_act & loader_wr & loader_a[31]. Entry stored = {loader_a[AW-1:0], loader_d}.
  - Accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise dropped and ovf set.
  - Bytes with loader_a[31]=0 are ignored; ovf is not set for them.
- ovf clears on reset and on a loader_act 0->1 transition.
- Deasserting loader_act does not flush the FIFO; buffered bytes still drain.
- Decision in IDLE, priority in order:
  1. Skip: if gs_rd_ack is high this cycle, gs_rd_req is ignored. The requester drops req on ack.
  2. Forced write: FIFO non-empty and starve_cnt==STARVE_MAX -> WRITE.
  3. Read: gs_rd_req -> READ.
  4. Idle write: FIFO non-empty -> WRITE.
  5. Otherwise stay IDLE.
- READ (1 cycle): mem_a<=gs_a captured on entry, mem_we=0. Next state RESP.
- RESP (1 cycle): gs_dout<=mem_q, gs_rd_ack<=1 registered, so data and ack are visible together on the following cycle. Next state IDLE.
  - Read latency: gs_rd_req sampled in IDLE at cycle T -> gs_rd_ack high at T+3.
  - Maximum read throughput: one read per 4 cycles.
- WRITE (1 cycle): FIFO popped on the IDLE->WRITE transition; mem_a/mem_d = popped entry, mem_we=1 for exactly this cycle. Next state IDLE.
  - Back-to-back writes occur every 2 cycles.
- starve_cnt:
  - +1 on each read grant while the FIFO is non-empty, saturating at STARVE_MAX.
  - Cleared on a write grant or whenever the FIFO is empty.
- Ordering: FIFO writes commit in arrival order. A read of an address with a pending FIFO write returns the old data; no bypass is provided.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- mem_we is never high in READ or RESP. mem_a holds its last value in IDLE.

Optional Feature:
GS_ROM_ARB_CSUM_EN
- Defined: adds output csum [7:0], the modulo-256 running sum of every mem_d committed with mem_we=1.
  - Cleared on reset and on a loader_act 0->1 transition.
  - Updates the cycle after the WRITE cycle.
- Undefined: csum port absent; no checksum logic.

Test Plan:
- Idle write: loader_act=1, one push a=0x8000_0123, d=0x5A with no reads -> WRITE two cycles later; mem_a=0x0123, mem_d=0x5A, mem_we=1 for 1 cycle; wr_idle returns to 1.
- Read latency: model memory holds 0xC3 at 0x7FFF; gs_rd_req with gs_a=0x7FFF at T -> gs_rd_ack=1 and gs_dout=0xC3 at T+3 only; no second read while req is dropped on ack.
- Overflow: 5 consecutive pushes with gs_rd_req held high (FIFO_DEPTH=4, no pop possible) -> 5th push dropped, ovf=1, fifo_level=4. Then loader_act 0->1 -> ovf=0.
- Starvation: gs_rd_req held continuously with re-request after each ack, FIFO holding 2 entries -> after 8 read grants, one WRITE is forced; starve_cnt back to 0; reads resume.
- Region filter and reset: push with loader_a[31]=0 -> fifo_level stays 0. Assert reset during READ -> no ack, all outputs 0, FIFO empty.
- CSUM (macro defined): write bytes 0xFF, 0x02, 0x10 -> csum=0x11 after the third WRITE; loader_act rising edge -> csum=0.
